// File: rtl/img2col_pkg.sv
// Shared constants and FSM encoding for the IMG2COL_GEMM result readout.
// Widths follow the project-wide size defines when they are provided.
`ifndef RESULT_SIZE
`define RESULT_SIZE 32
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 8
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif

package img2col_pkg;

  localparam int DW = `RESULT_SIZE;
  localparam int CW = `TENSOR_SIZE;
  localparam int KW = `KERNEL_SIZE;
  localparam int SW = `STRIDE_SIZE;
  localparam int NW = `KERNEL_NUMS_SIZE;

  localparam int AW      = 3 * CW;
  localparam int RAM_LAT = 1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DIV    = 3'd1;
  localparam state_t S_MUL1   = 3'd2;
  localparam state_t S_MUL2   = 3'd3;
  localparam state_t S_STREAM = 3'd4;
  localparam state_t S_DRAIN  = 3'd5;

endpackage

// File: rtl/result_streamer_if.sv
// Result stream handshake: dout/dout_valid/dout_last from the streamer,
// dout_ready back from the consumer.
interface result_streamer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO buffering RAM read data for the stream.
// Ports: push/push_data in, pop/pop_data out, empty and count status.
module result_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 3,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    output logic [DW-1:0]   pop_data,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt_q != '0);
    // a full FIFO may still take a word when the head leaves this cycle
    assign do_push = push && ((cnt_q != CNTW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = nxt(wr_ptr_q);
        if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;

endmodule

// File: rtl/result_streamer.sv
// Reads the finished GEMM result RAM and streams it out with valid/ready.
// Ports: compute_done + layer config in, RAM read port, dout_if stream, status.
module result_streamer
    import img2col_pkg::*;
#(
    parameter int DW      = img2col_pkg::DW,
    parameter int AW      = img2col_pkg::AW,
    parameter int CW      = img2col_pkg::CW,
    parameter int RAM_LAT = img2col_pkg::RAM_LAT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          compute_done,
    input  logic [CW-1:0] tensor_size,
    input  logic [CW-1:0] kernel_size,
    input  logic [CW-1:0] stride,
    input  logic [CW-1:0] kernel_nums,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          w_done,
    output logic          busy,
    output logic          cfg_err,
    result_streamer_if.master dout_if
);

    localparam int DEPTH = RAM_LAT + 2;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int IFW   = $clog2(RAM_LAT + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   s_q, s_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   div_q, div_d;
    logic [CW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   side_q, side_d;
    logic [2*CW-1:0] sq_q, sq_d;
    logic [AW-1:0]   total_q, total_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]   emit_cnt_q, emit_cnt_d;
    logic            w_done_q, w_done_d;
    logic            cfg_err_q, cfg_err_d;
    logic [RAM_LAT-1:0] pipe_q, pipe_d;

    logic [IFW-1:0]  inflight;
    logic            rd_en;
    logic            cfg_bad;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CNTW-1:0] fifo_cnt;
    logic [DW-1:0]   fifo_data;
    logic            last_word;

    result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (pipe_q[RAM_LAT-1]),
        .push_data (ram_rd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + IFW'(pipe_q[i]);
        end
    end

    // reserve a FIFO slot for every outstanding read so it never overflows
    assign rd_en = (state_q == S_STREAM) && (rd_cnt_q < total_q) &&
                   ((int'(fifo_cnt) + int'(inflight)) < DEPTH);

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_en;
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign fifo_pop  = !fifo_empty && dout_if.dout_ready;
    assign last_word = (emit_cnt_q == total_q - 1'b1);

    assign cfg_bad = (stride == '0) || (kernel_size > tensor_size) ||
                     (kernel_size == '0) || (kernel_nums == '0);

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        div_d      = div_q;
        quo_d      = quo_q;
        side_d     = side_q;
        sq_d       = sq_q;
        total_d    = total_q;
        rd_cnt_d   = rd_cnt_q;
        emit_cnt_d = emit_cnt_q;
        w_done_d   = 1'b0;
        cfg_err_d  = cfg_err_q;
        if (rd_en)    rd_cnt_d   = rd_cnt_q + 1'b1;
        if (fifo_pop) emit_cnt_d = emit_cnt_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (compute_done) begin
                    s_d       = stride;
                    n_d       = kernel_nums;
                    cfg_err_d = cfg_bad;
                    if (!cfg_bad) begin
                        div_d   = tensor_size - kernel_size;
                        quo_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (div_q >= s_q) begin
                    div_d = div_q - s_q;
                    quo_d = quo_q + 1'b1;
                end else begin
                    side_d  = quo_q + 1'b1;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: begin
                sq_d    = {{CW{1'b0}}, side_q} * {{CW{1'b0}}, side_q};
                state_d = S_MUL2;
            end
            S_MUL2: begin
                total_d    = AW'(sq_q) * AW'(n_q);
                rd_cnt_d   = '0;
                emit_cnt_d = '0;
                w_done_d   = 1'b1;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (rd_cnt_d == total_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_pop && last_word) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            side_q     <= '0;
            sq_q       <= '0;
            total_q    <= '0;
            rd_cnt_q   <= '0;
            emit_cnt_q <= '0;
            w_done_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            side_q     <= side_d;
            sq_q       <= sq_d;
            total_q    <= total_d;
            rd_cnt_q   <= rd_cnt_d;
            emit_cnt_q <= emit_cnt_d;
            w_done_q   <= w_done_d;
            cfg_err_q  <= cfg_err_d;
            pipe_q     <= pipe_d;
        end
    end

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = rd_cnt_q;
    assign w_done      = w_done_q;
    assign busy        = (state_q != S_IDLE);
    assign cfg_err     = cfg_err_q;

    assign dout_if.dout       = fifo_empty ? '0 : fifo_data;
    assign dout_if.dout_valid = !fifo_empty;
    assign dout_if.dout_last  = !fifo_empty && last_word;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: config table, backpressure,
// config errors and mid-frame reset against a latency-1 RAM model.
module tb_result_streamer;

    typedef struct {
        logic [7:0] t;
        logic [7:0] k;
        logic [7:0] s;
        logic [7:0] n;
        bit         err;
        int         words;
        int         lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        compute_done = 1'b0;
    logic [7:0]  tensor_size = '0;
    logic [7:0]  kernel_size = '0;
    logic [7:0]  stride = '0;
    logic [7:0]  kernel_nums = '0;
    logic        ram_rd_en;
    logic [23:0] ram_rd_addr;
    logic [31:0] ram_rd_data = '0;
    logic        w_done;
    logic        busy;
    logic        cfg_err;

    result_streamer_if #(.DW(32)) sif ();

    result_streamer dut (
        .clk          (clk),
        .rstn         (rstn),
        .compute_done (compute_done),
        .tensor_size  (tensor_size),
        .kernel_size  (kernel_size),
        .stride       (stride),
        .kernel_nums  (kernel_nums),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .w_done       (w_done),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .dout_if      (sif.master)
    );

    always #5 clk = ~clk;

    // result RAM: word i holds i+100, one cycle read latency
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= 32'(ram_rd_addr) + 32'd100;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] hs_data[$];
    bit          hs_last[$];
    int          hs_cyc[$];
    int          w_cnt = 0, w_cyc = 0, rd_total = 0;
    int          exp_addr = 0, rd_frame = 0, pop_frame = 0;
    int          addr_bad = 0, stall_bad = 0, occ_bad = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (w_done) begin
            w_cnt++;
            w_cyc = cyc;
            exp_addr = 0;
            rd_frame = 0;
            pop_frame = 0;
        end
        if (ram_rd_en) begin
            if (ram_rd_addr !== 24'(exp_addr)) addr_bad++;
            exp_addr++;
            rd_total++;
            rd_frame++;
            if (rd_frame - pop_frame > 3) occ_bad++;
        end
        if (rstn && prev_stall &&
            (!sif.dout_valid || sif.dout !== prev_dout ||
             sif.dout_last !== prev_last)) stall_bad++;
        if (sif.dout_valid && sif.dout_ready) begin
            hs_data.push_back(sif.dout);
            hs_last.push_back(sif.dout_last);
            hs_cyc.push_back(cyc);
            pop_frame++;
        end
        prev_stall = rstn && sif.dout_valid && !sif.dout_ready;
        prev_dout = sif.dout;
        prev_last = sif.dout_last;
    end

    int checks = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, longint'(ram_rd_en), 0);
        chk({tag, "_rd_addr"}, longint'(ram_rd_addr), 0);
        chk({tag, "_dout"}, longint'(sif.dout), 0);
        chk({tag, "_valid"}, longint'(sif.dout_valid), 0);
        chk({tag, "_last"}, longint'(sif.dout_last), 0);
        chk({tag, "_w_done"}, longint'(w_done), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_cfg_err"}, longint'(cfg_err), 0);
    endtask

    task automatic run(input string tag, input vec_t v,
                       input bit rnd, input bit inject);
        int hb = hs_data.size();
        int wb = w_cnt;
        int rb = rd_total;
        int sb = stall_bad;
        int ab = addr_bad;
        int ob = occ_bad;
        int cdc;
        int b = 0;
        int inj = 0;
        int n;
        @(posedge clk);
        #1;
        tensor_size = v.t;
        kernel_size = v.k;
        stride = v.s;
        kernel_nums = v.n;
        compute_done = 1'b1;
        cdc = cyc;
        @(posedge clk);
        #1;
        compute_done = 1'b0;
        while ((busy || b < 8) && b < 3000) begin
            sif.dout_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (inj == 1) begin
                compute_done = 1'b0;
                inj = 2;
            end
            if (inject && inj == 0 && hs_data.size() - hb >= 3) begin
                tensor_size = 8'd9;
                kernel_size = 8'd3;
                stride = 8'd1;
                kernel_nums = 8'd3;
                compute_done = 1'b1;
                inj = 1;
            end
            @(posedge clk);
            #1;
            b++;
        end
        compute_done = 1'b0;
        sif.dout_ready = 1'b1;
        n = hs_data.size() - hb;
        chk({tag, "_timeout"}, longint'(b < 3000), 1);
        chk({tag, "_cfg_err"}, longint'(cfg_err), longint'(v.err));
        chk({tag, "_w_done_cnt"}, w_cnt - wb, v.err ? 0 : 1);
        chk({tag, "_words"}, n, v.words);
        chk({tag, "_reads"}, rd_total - rb, v.words);
        chk({tag, "_busy_end"}, longint'(busy), 0);
        chk({tag, "_valid_end"}, longint'(sif.dout_valid), 0);
        chk({tag, "_addr_seq"}, addr_bad - ab, 0);
        chk({tag, "_stall_hold"}, stall_bad - sb, 0);
        chk({tag, "_occupancy"}, occ_bad - ob, 0);
        if (inject) chk({tag, "_inject_seen"}, inj, 2);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), hs_data[hb+i], 100 + i);
            chk($sformatf("%s_last%0d", tag, i), longint'(hs_last[hb+i]),
                longint'(i == v.words - 1));
        end
        if (!v.err && !rnd && n > 0) begin
            chk({tag, "_latency"}, w_cyc - cdc, v.lat);
            chk({tag, "_fill"}, hs_cyc[hb] - w_cyc, 2);
            chk({tag, "_rate"}, hs_cyc[hb+n-1] - hs_cyc[hb], n - 1);
        end
    endtask

    vec_t vt[9];

    initial begin
        int hb;
        int b;
        int lasts;
        vec_t base;

        vt[0] = '{8'd5,  8'd3, 8'd1, 8'd2, 1'b0, 18, 6};
        vt[1] = '{8'd7,  8'd3, 8'd2, 8'd1, 1'b0, 9,  6};
        vt[2] = '{8'd4,  8'd4, 8'd3, 8'd1, 1'b0, 1,  4};
        vt[3] = '{8'd10, 8'd2, 8'd4, 8'd3, 1'b0, 27, 6};
        vt[4] = '{8'd9,  8'd1, 8'd8, 8'd2, 1'b0, 8,  5};
        vt[5] = '{8'd5,  8'd3, 8'd0, 8'd1, 1'b1, 0,  0};
        vt[6] = '{8'd5,  8'd6, 8'd1, 8'd1, 1'b1, 0,  0};
        vt[7] = '{8'd5,  8'd0, 8'd1, 8'd1, 1'b1, 0,  0};
        vt[8] = '{8'd5,  8'd3, 8'd1, 8'd1, 1'b0, 9,  6};
        base = vt[0];

        sif.dout_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run($sformatf("vec%0d", i), vt[i], 1'b0, 1'b0);
        end

        run("backpressure", base, 1'b1, 1'b0);

        // abort a frame after seven words
        hb = hs_data.size();
        @(posedge clk);
        #1;
        tensor_size = base.t;
        kernel_size = base.k;
        stride = base.s;
        kernel_nums = base.n;
        compute_done = 1'b1;
        @(posedge clk);
        #1;
        compute_done = 1'b0;
        b = 0;
        while (hs_data.size() - hb < 7 && b < 500) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("midrst_timeout", longint'(b < 500), 1);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_busy_hold", longint'(busy), 0);
        lasts = 0;
        for (int i = hb; i < hs_data.size(); i++) lasts += int'(hs_last[i]);
        chk("midrst_no_last", lasts, 0);
        rstn = 1'b1;

        run("restart", base, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
